// File: rtl/sha256_job_sched.sv
// Job scheduler for the simplified_sha256 core: queues host jobs, starts the core once per job,
// watches for start/run hangs, and returns one completion record per job.
//
// state       | meaning
// IDLE        | waiting for a queued job and an idle core
// ISSUE       | start pulse, clear per-job counters
// WAIT_BUSY   | waiting for core_done to fall (start watchdog)
// WAIT_DONE   | core running, counting low cycles (run watchdog)
// RECOVER     | core held in reset for two cycles after a hang
// REPORT      | completion record offered to the host
module sha256_job_sched #(
  parameter int DEPTH         = 4,
  parameter int TAG_W         = 4,
  parameter int START_TIMEOUT = 8,
  parameter int RUN_TIMEOUT   = 4096
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             job_valid,
  output logic             job_ready,
  input  logic [15:0]      job_msg_addr,
  input  logic [15:0]      job_out_addr,
  input  logic [TAG_W-1:0] job_tag,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [TAG_W-1:0] res_tag,
  output logic [1:0]       res_status,
  output logic [31:0]      res_cycles,
  output logic             core_start,
  output logic [15:0]      core_message_addr,
  output logic [15:0]      core_output_addr,
  output logic             core_rst_n,
  input  logic             core_done,
  output logic             busy,
  output logic [15:0]      jobs_done
);
  localparam int AW = $clog2(DEPTH);
  localparam int WW = $clog2(START_TIMEOUT + 1);
  localparam logic [AW:0]   PTR_ONE = 1;
  localparam logic [WW-1:0] WAIT_LIM = WW'(START_TIMEOUT);
  localparam logic [31:0]   RUN_LIM = RUN_TIMEOUT;

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_WAIT_BUSY, S_WAIT_DONE, S_RECOVER, S_REPORT
  } state_t;

  state_t state, state_nxt;

  logic [15:0]      fifo_msg [DEPTH];
  logic [15:0]      fifo_out [DEPTH];
  logic [TAG_W-1:0] fifo_tag [DEPTH];
  logic [AW:0]      wr_ptr, rd_ptr;
  logic             full, empty, push, pop;

  logic [WW-1:0] wait_cnt, wait_cnt_nxt;
  logic          rec_cnt, rec_cnt_nxt;
  logic [31:0]   cyc_nxt, cyc_inc;
  logic [1:0]    status_nxt;

  // Extra pointer bit distinguishes full from empty.
  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign job_ready = !full;
  assign push      = job_valid && !full;
  assign pop       = (state == S_IDLE) && !empty && core_done;

  assign res_valid  = (state == S_REPORT);
  assign busy       = (state != S_IDLE) || !empty;
  assign core_rst_n = reset_n && (state != S_RECOVER);

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_msg[wr_ptr[AW-1:0]] <= job_msg_addr;
      fifo_out[wr_ptr[AW-1:0]] <= job_out_addr;
      fifo_tag[wr_ptr[AW-1:0]] <= job_tag;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr            <= '0;
      rd_ptr            <= '0;
      core_message_addr <= '0;
      core_output_addr  <= '0;
      res_tag           <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop) begin
        rd_ptr            <= rd_ptr + PTR_ONE;
        core_message_addr <= fifo_msg[rd_ptr[AW-1:0]];
        core_output_addr  <= fifo_out[rd_ptr[AW-1:0]];
        res_tag           <= fifo_tag[rd_ptr[AW-1:0]];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      wait_cnt   <= '0;
      rec_cnt    <= 1'b0;
      res_cycles <= '0;
      res_status <= '0;
      jobs_done  <= '0;
    end else begin
      state      <= state_nxt;
      wait_cnt   <= wait_cnt_nxt;
      rec_cnt    <= rec_cnt_nxt;
      res_cycles <= cyc_nxt;
      res_status <= status_nxt;
      if (state == S_REPORT && res_ready) jobs_done <= jobs_done + 16'd1;
    end
  end

  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    rec_cnt_nxt  = rec_cnt;
    cyc_nxt      = res_cycles;
    status_nxt   = res_status;
    core_start   = 1'b0;
    cyc_inc      = (res_cycles == '1) ? res_cycles : res_cycles + 32'd1;
    case (state)
      S_IDLE: if (pop) state_nxt = S_ISSUE;
      S_ISSUE: begin
        core_start   = 1'b1;
        wait_cnt_nxt = '0;
        rec_cnt_nxt  = 1'b0;
        cyc_nxt      = '0;
        state_nxt    = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        if (!core_done) begin
          cyc_nxt   = cyc_inc;
          state_nxt = S_WAIT_DONE;
        end else begin
          wait_cnt_nxt = wait_cnt + WW'(1);
          if (wait_cnt_nxt == WAIT_LIM) begin
            status_nxt = 2'b01;
            state_nxt  = S_RECOVER;
          end
        end
      end
      S_WAIT_DONE: begin
        if (core_done) begin
          status_nxt = 2'b00;
          state_nxt  = S_REPORT;
        end else begin
          cyc_nxt = cyc_inc;
          if (cyc_inc == RUN_LIM) begin
            status_nxt = 2'b10;
            state_nxt  = S_RECOVER;
          end
        end
      end
      S_RECOVER: begin
        if (rec_cnt) state_nxt = S_REPORT;
        else         rec_cnt_nxt = 1'b1;
      end
      S_REPORT: if (res_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end
endmodule

// File: tb/tb_sha256_job_sched.sv
// Scoreboard bench for sha256_job_sched: behavioural core model, randomized jobs,
// expected records queued at push time and checked by an independent monitor.
module tb_sha256_job_sched;
  localparam int TAG_W    = 4;
  localparam int START_TO = 8;
  localparam int RUN_TO   = 16;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             job_valid;
  logic             job_ready;
  logic [15:0]      job_msg_addr;
  logic [15:0]      job_out_addr;
  logic [TAG_W-1:0] job_tag;
  logic             res_valid;
  logic             res_ready = 1'b0;
  logic [TAG_W-1:0] res_tag;
  logic [1:0]       res_status;
  logic [31:0]      res_cycles;
  logic             core_start;
  logic [15:0]      core_message_addr;
  logic [15:0]      core_output_addr;
  logic             core_rst_n;
  logic             core_done = 1'b1;
  logic             busy;
  logic [15:0]      jobs_done;

  always #5 clk = ~clk;

  sha256_job_sched #(
    .DEPTH(4), .TAG_W(TAG_W), .START_TIMEOUT(START_TO), .RUN_TIMEOUT(RUN_TO)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .job_valid(job_valid), .job_ready(job_ready),
    .job_msg_addr(job_msg_addr), .job_out_addr(job_out_addr), .job_tag(job_tag),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_tag(res_tag), .res_status(res_status), .res_cycles(res_cycles),
    .core_start(core_start), .core_message_addr(core_message_addr),
    .core_output_addr(core_output_addr), .core_rst_n(core_rst_n),
    .core_done(core_done), .busy(busy), .jobs_done(jobs_done)
  );

  typedef struct {
    logic [TAG_W-1:0] tag;
    logic [1:0]       status;
    logic [31:0]      cycles;
  } rec_t;

  // mode 0: done low for len cycles; 1: done stuck high; 2: done stuck low
  typedef struct {
    int          mode;
    int          len;
    logic [15:0] msg;
    logic [15:0] out;
  } job_t;

  rec_t exp_q[$];
  job_t mode_q[$];
  int   total = 0;
  int   bad = 0;
  bit   force_bp = 1'b0;
  int   start_count = 0;
  int   exp_jobs = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic rec_t model(input logic [TAG_W-1:0] tag, input int mode, input int len);
    rec_t r;
    r.tag = tag;
    if (mode == 1) begin
      r.status = 2'b01; r.cycles = 0;
    end else if (mode == 2 || len >= RUN_TO) begin
      r.status = 2'b10; r.cycles = RUN_TO;
    end else begin
      r.status = 2'b00; r.cycles = len;
    end
    return r;
  endfunction

  // Behavioural core: done falls the cycle after start, reset forces it back high.
  int  low_left = 0;
  bit  stuck = 1'b0;
  always @(posedge clk) begin
    if (!reset_n) mode_q.delete();
    if (!core_rst_n) begin
      core_done <= 1'b1;
      low_left  <= 0;
      stuck     <= 1'b0;
    end else if (core_start) begin
      start_count++;
      if (mode_q.size() == 0) begin
        chk("start_without_job", 1, 0);
      end else begin
        job_t j;
        j = mode_q.pop_front();
        chk("start_msg_addr", core_message_addr, j.msg);
        chk("start_out_addr", core_output_addr, j.out);
        if (j.mode == 0) begin
          core_done <= 1'b0; low_left <= j.len;
        end else if (j.mode == 2) begin
          core_done <= 1'b0; stuck <= 1'b1;
        end
      end
    end else if (!core_done && !stuck) begin
      if (low_left == 1) core_done <= 1'b1;
      low_left <= low_left - 1;
    end
  end

  int low_run = 0;
  always @(negedge clk) begin
    if (!reset_n) low_run = 0;
    else if (!core_rst_n) low_run++;
    else if (low_run != 0) begin
      chk("core_rst_len", low_run, 2);
      low_run = 0;
    end
  end

  // Monitor: drives res_ready, pops expected records on handshake, checks hold stability.
  bit   holding = 1'b0;
  rec_t held;
  always @(negedge clk) begin
    if (!reset_n) begin
      exp_q.delete();
      exp_jobs = 0;
      holding = 1'b0;
      res_ready = 1'b0;
    end else begin
      if (holding) begin
        chk("hold_valid", res_valid, 1);
        chk("hold_tag", res_tag, held.tag);
        chk("hold_status", res_status, held.status);
        chk("hold_cycles", res_cycles, held.cycles);
      end
      res_ready = force_bp ? 1'b0 : ($urandom_range(3) != 0);
      holding = 1'b0;
      if (res_valid) begin
        if (res_ready) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_record", 1, 0);
          end else begin
            rec_t e;
            e = exp_q.pop_front();
            chk("rec_tag", res_tag, e.tag);
            chk("rec_status", res_status, e.status);
            chk("rec_cycles", res_cycles, e.cycles);
          end
          chk("jobs_done", jobs_done, exp_jobs & 16'hffff);
          exp_jobs++;
        end else begin
          holding = 1'b1;
          held.tag = res_tag; held.status = res_status; held.cycles = res_cycles;
        end
      end
    end
  end

  task automatic push_job(input logic [TAG_W-1:0] tag, input int mode, input int len,
                          input logic [15:0] msg, input logic [15:0] out);
    job_t j;
    int n = 0;
    @(negedge clk);
    job_valid = 1'b1; job_tag = tag; job_msg_addr = msg; job_out_addr = out;
    while (!job_ready && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (!job_ready) begin
      chk("push_timeout", 0, 1);
      job_valid = 1'b0;
      return;
    end
    j.mode = mode; j.len = len; j.msg = msg; j.out = out;
    exp_q.push_back(model(tag, mode, len));
    mode_q.push_back(j);
    @(posedge clk);
    #1 job_valid = 1'b0;
  endtask

  task automatic push_rand(input logic [TAG_W-1:0] tag, input int mode, input int len);
    push_job(tag, mode, len, 16'($urandom), 16'($urandom));
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk(name, (exp_q.size() == 0 && !busy), 1);
  endtask

  task automatic wait_start(input string name);
    int n = 0;
    @(negedge clk);
    while (!core_start && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk(name, core_start, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, sc;
    reset_n = 1'b0; job_valid = 1'b0; job_tag = '0; job_msg_addr = '0; job_out_addr = '0;
    repeat (3) @(negedge clk);
    chk("rst_job_ready", job_ready, 1);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_core_start", core_start, 0);
    chk("rst_busy", busy, 0);
    chk("rst_jobs_done", jobs_done, 0);
    chk("rst_core_rst_n", core_rst_n, 0);
    chk("rst_res_cycles", res_cycles, 0);
    chk("rst_msg_addr", core_message_addr, 0);
    @(negedge clk) reset_n = 1'b1;

    // single job: start exactly two cycles after the push
    push_job(3, 0, 12, 16'h0000, 16'h0100);
    @(negedge clk) chk("lat_cycle1_start", core_start, 0);
    @(negedge clk) chk("lat_cycle2_start", core_start, 1);
    chk("lat_msg_addr", core_message_addr, 16'h0000);
    chk("lat_out_addr", core_output_addr, 16'h0100);
    @(negedge clk) chk("start_one_cycle", core_start, 0);
    wait_idle("idle_single");
    chk("single_jobs_done", jobs_done, 1);

    // FIFO fills while a prior job runs
    push_rand(15, 0, 14);
    for (int i = 0; i < 4; i++) push_rand(TAG_W'(i), 0, $urandom_range(1, 15));
    @(negedge clk) chk("fifo_full_ready", job_ready, 0);
    push_rand(4, 0, 1);
    wait_idle("idle_fifo");

    // start timeout: ISSUE then 8 WAIT_BUSY cycles before the core reset
    push_rand(5, 1, 0);
    wait_start("start_seen_sto");
    n = 0;
    while (core_rst_n && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("start_to_latency", n, START_TO + 1);
    wait_idle("idle_sto");

    // run timeout followed by a normal job; run-length boundaries
    push_rand(6, 2, 0);
    push_rand(7, 0, 9);
    push_rand(8, 0, RUN_TO - 1);
    push_rand(9, 0, RUN_TO);
    push_rand(10, 0, 1);
    wait_idle("idle_rto");

    // backpressure: record held, no new start, FIFO still fills
    force_bp = 1'b1;
    push_rand(10, 0, 5);
    n = 0;
    while (!res_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("bp_res_valid", res_valid, 1);
    sc = start_count;
    for (int i = 0; i < 4; i++) push_rand(TAG_W'(11 + i), 0, $urandom_range(1, 15));
    repeat (20) @(negedge clk);
    chk("bp_no_start", start_count, sc);
    chk("bp_fifo_full", job_ready, 0);
    chk("bp_still_valid", res_valid, 1);
    force_bp = 1'b0;
    wait_idle("idle_bp");

    // randomized mix
    for (int i = 0; i < 30; i++) begin
      int r, mode;
      r = $urandom_range(9);
      mode = (r < 8) ? 0 : ((r == 8) ? 1 : 2);
      push_rand(TAG_W'($urandom), mode, $urandom_range(1, 20));
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    wait_idle("idle_random");
    chk("random_jobs_done", jobs_done, exp_jobs & 16'hffff);

    // reset in the middle of a job with two queued
    push_rand(1, 0, 15);
    push_rand(2, 0, 3);
    push_rand(3, 0, 3);
    n = 0;
    while (core_done && n < 50) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    chk("mid_running", core_done, 0);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_res_valid", res_valid, 0);
    chk("mid_rst_core_rst_n", core_rst_n, 0);
    chk("mid_rst_job_ready", job_ready, 1);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("post_rst_jobs_done", jobs_done, 0);
    chk("post_rst_busy", busy, 0);
    chk("post_rst_cycles", res_cycles, 0);
    push_rand(4, 0, 7);
    wait_idle("idle_post_rst");
    chk("post_rst_one_job", jobs_done, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
